cam_lookup_ctrl: RTL

Request-side initiator for the team's CAM. Accepts one key per transaction on a valid/ready port and searches the CAM for it. On a hit it returns the matching index. On a miss it inserts the key at a round-robin allocation slot, first reading out the victim when the CAM is full, and returns the new index. It sits between a client pipeline and the CAM, and is the only driver of the CAM's read, write and search ports.

---
 rtl/cam_lookup_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/cam_lookup_ctrl.sv
// cam_lookup_ctrl: CAM request initiator; searches for a key, inserts it round-robin on a miss
// (reading out the victim once the CAM is full) and returns the index.
module cam_lookup_ctrl #(
    parameter int ARRAY_WIDTH_LOG2 = 5,
    parameter int ARRAY_SIZE_LOG2  = 5,
    localparam int DW = 2 ** ARRAY_WIDTH_LOG2,
    localparam int AW = ARRAY_SIZE_LOG2,
    localparam int OW = ARRAY_SIZE_LOG2 + 1
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [DW-1:0] req_key_i,
    output logic          resp_valid_o,
    input  logic          resp_ready_i,
    output logic          resp_hit_o,
    output logic [AW-1:0] resp_index_o,
    output logic          resp_evict_o,
    output logic [DW-1:0] resp_evict_key_o,
    output logic [OW-1:0] occupancy_o,
    output logic          cam_read_o,
    output logic [AW-1:0] cam_read_index_o,
    input  logic          cam_read_valid_i,
    input  logic [DW-1:0] cam_read_value_i,
    output logic          cam_write_o,
    output logic [AW-1:0] cam_write_index_o,
    output logic [DW-1:0] cam_write_data_o,
    output logic          cam_search_o,
    output logic [DW-1:0] cam_search_data_o,
    input  logic          cam_search_valid_i,
    input  logic [AW-1:0] cam_search_index_i
);
    typedef enum logic [2:0] {IDLE, SEARCH, EVICT_RD, WRITE, RESP} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] key_q, evict_key_q;
    logic [AW-1:0] idx_q, alloc_q;
    logic [OW-1:0] occ_q;
    logic          hit_q, evict_q;

    // occupancy saturates at N, so its top bit alone means full
    logic full;
    assign full = occ_q[AW];

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     state_d = req_valid_i ? SEARCH : IDLE;
            SEARCH:   state_d = cam_search_valid_i ? RESP : full ? EVICT_RD : WRITE;
            EVICT_RD: state_d = WRITE;
            WRITE:    state_d = RESP;
            RESP:     state_d = resp_ready_i ? IDLE : RESP;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = reset_i && state_q == IDLE;
        cam_search_o = state_q == SEARCH;
        cam_read_o   = state_q == EVICT_RD;
        cam_write_o  = state_q == WRITE;
        resp_valid_o = state_q == RESP;
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            key_q       <= '0;
            hit_q       <= 1'b0;
            idx_q       <= '0;
            evict_q     <= 1'b0;
            evict_key_q <= '0;
            alloc_q     <= '0;
            occ_q       <= '0;
        end else begin
            if (state_q == IDLE && req_valid_i) key_q <= req_key_i;
            if (state_q == SEARCH) begin
                hit_q <= cam_search_valid_i;
                idx_q <= cam_search_valid_i ? cam_search_index_i : alloc_q;
            end
            if (state_q == EVICT_RD) begin
                evict_q     <= cam_read_valid_i;
                evict_key_q <= cam_read_valid_i ? cam_read_value_i : '0;
                idx_q       <= alloc_q;
            end
            if (state_q == WRITE) begin
                alloc_q <= alloc_q + AW'(1);
                occ_q   <= occ_q + OW'(!full);
            end
            if (state_q == RESP && resp_ready_i) begin
                hit_q       <= 1'b0;
                evict_q     <= 1'b0;
                evict_key_q <= '0;
            end
        end
    end

    assign resp_hit_o        = hit_q;
    assign resp_index_o      = idx_q;
    assign resp_evict_o      = evict_q;
    assign resp_evict_key_o  = evict_key_q;
    assign occupancy_o       = occ_q;
    assign cam_read_index_o  = alloc_q;
    assign cam_write_index_o = idx_q;
    assign cam_write_data_o  = key_q;
    assign cam_search_data_o = key_q;
endmodule
